pipe_skid_reg: RTL and testbench
================================

// Module: pipe_skid_reg
// PURPOSE
//   Parametrised elastic pipeline register: next generation of the plain enable register.
//   Adds valid/ready handshake on both sides, a 2-entry skid buffer (full throughput with registered in_ready),
//   synchronous flush and an occupancy count.
//   Placed between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB): stalls propagate without comb ready paths, flush kills in-flight data.
// PARAMETERS
//   WIDTH      32   payload width in bits (>=1)
//   RESET_VAL  0    value loaded into both data entries on reset/flush (WIDTH bits)
// PORTS
//   clk         in   1      clock, all state updates on posedge
//   rst         in   1      asynchronous, active-high reset
//   flush       in   1      synchronous kill of all held entries
//   in_valid    in   1      upstream presents in_data
//   in_ready    out  1      block accepts in_data this cycle
//   in_data     in   WIDTH  upstream payload
//   out_valid   out  1      out_data holds a valid entry
//   out_ready   in   1      downstream consumes out_data this cycle
//   out_data    out  WIDTH  oldest held entry
//   occupancy   out  2      entries held: 0, 1 or 2
// BEHAVIOUR
//   Storage: main reg (head, drives out_data), skid reg (second entry); state EMPTY/ONE/FULL.
//   in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//   Outputs are pure functions of state:
//   - in_ready = (state != FULL) & ~rst; out_valid = (state != EMPTY).
//   - occupancy = 0/1/2 for EMPTY/ONE/FULL; out_data = main.
//   Reset (async, any time, incl. mid-transfer): state=EMPTY, main=skid=RESET_VAL,
//     out_valid=0, occupancy=0, in_ready=0 while rst high, 1 on first cycle after release.
//   flush (sync, priority over all transfers): next state=EMPTY, main=skid=RESET_VAL;
//     in_fire in a flush cycle is discarded; out_fire in a flush cycle counts as consumed.
//   Transitions (no flush):
//     EMPTY: in_fire -> ONE, main<=in_data; else stay.
//     ONE:   in_fire&out_fire -> ONE, main<=in_data; in_fire&~out_fire -> FULL, skid<=in_data;
//            ~in_fire&out_fire -> EMPTY; else stay.
//     FULL:  in_ready=0; out_fire -> ONE, main<=skid; else stay.
//   Latency: data accepted at edge N is on out_data with out_valid=1 after edge N (1 cycle).
//   Throughput: 1 entry/cycle sustained when out_ready held high; strict FIFO order.
//   Stall stability: while out_valid & ~out_ready, out_data and out_valid are unchanged next cycle.
//   in_data sampled only on in_fire; unaccepted in_data has no effect.
//   Holding entries (main in EMPTY, skid in EMPTY/ONE) keep last value; only main is observable.
// TESTING
//   1. Reset: assert rst asynchronously mid-cycle with state FULL ->
//      out_valid=0, occupancy=0, out_data=RESET_VAL immediately, in_ready=0 until rst low.
//   2. Streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles ->
//      out_data 0x11,0x22,0x33 on following cycles, occupancy stays 1, in_ready stays 1.
//   3. Skid: out_ready=0, push 0xA1 then 0xA2 -> occupancy 2, in_ready=0, out_data=0xA1 held;
//      raise out_ready -> 0xA1 then 0xA2 out, in_ready=1 after first pop.
//   4. Flush: FULL with 0xB1/0xB2, assert flush with in_valid=1 data 0xB3 ->
//      next cycle EMPTY, out_valid=0, 0xB3 never appears at output.
//   5. Simultaneous in/out in ONE: head 0xC1, in 0xC2, out_ready=1 -> next cycle ONE, out_data=0xC2.
//   6. Random valid/ready (10k cycles) vs scoreboard queue -> no loss/dup/reorder, stall stability holds.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - elastic two-entry pipeline register with valid/ready, flush and occupancy
module pipe_skid_reg #(
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire, out_fire;

    // Handshake outputs depend only on registered state, so no ready path crosses the block.
    assign in_ready  = (state_q != FULL) & ~rst;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - self-checking bench for pipe_skid_reg against a queue model
module tb_pipe_skid_reg;

    localparam int          WIDTH = 32;
    localparam logic [31:0] RV    = 32'hDEAD_BEEF;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    int tests = 0;
    int fails = 0;

    pipe_skid_reg #(.WIDTH(WIDTH), .RESET_VAL(RV)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the held entries are just a FIFO of at most two items.
    logic [WIDTH-1:0] q[$];
    logic             m_in_fire, m_out_fire;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else begin
            m_in_fire  = in_valid && (q.size() < 2);
            m_out_fire = out_ready && (q.size() > 0);
            if (flush) begin
                q.delete();
            end else begin
                if (m_out_fire) void'(q.pop_front());
                if (m_in_fire) q.push_back(in_data);
            end
        end
    end

    logic             prev_stall = 1'b0;
    logic             prev_flush = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;

    always @(negedge clk) begin
        check("occupancy", {30'd0, occupancy}, q.size());
        check("out_valid", {31'd0, out_valid}, {31'd0, (q.size() > 0)});
        check("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2) && !rst});
        if (q.size() > 0) check("out_data", out_data, q[0]);
        if (prev_stall && !prev_flush && !rst) begin
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_data", out_data, prev_data);
        end
        prev_stall = out_valid && !out_ready && !rst;
        prev_flush = flush;
        prev_data  = out_data;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        #1 check("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_data", out_data, RV);

        // Streaming with downstream always ready.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step(); check("stream0", out_data, 32'h11); check("stream0_occ", {30'd0, occupancy}, 32'd1);
        in_data = 32'h22;
        step(); check("stream1", out_data, 32'h22); check("stream1_rdy", {31'd0, in_ready}, 32'd1);
        in_data = 32'h33;
        step(); check("stream2", out_data, 32'h33); check("stream2_occ", {30'd0, occupancy}, 32'd1);
        in_valid = 1'b0;
        step(); check("stream_drain", {31'd0, out_valid}, 32'd0);

        // Skid: stall downstream and fill both entries.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA1;
        step();
        in_data = 32'hA2;
        step();
        in_data = 32'hAF;
        check("skid_occ", {30'd0, occupancy}, 32'd2);
        check("skid_rdy", {31'd0, in_ready}, 32'd0);
        check("skid_head", out_data, 32'hA1);
        step();
        check("skid_hold", out_data, 32'hA1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step(); check("skid_pop1", out_data, 32'hA2); check("skid_pop1_rdy", {31'd0, in_ready}, 32'd1);
        step(); check("skid_pop2", {31'd0, out_valid}, 32'd0);

        // Flush while full, with a concurrent push that must vanish.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hB1;
        step();
        in_data = 32'hB2;
        step();
        flush   = 1'b1;
        in_data = 32'hB3;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_occ", {30'd0, occupancy}, 32'd0);
        check("flush_data", out_data, RV);
        out_ready = 1'b1;
        step(); check("flush_no_b3", {31'd0, out_valid}, 32'd0);

        // Simultaneous push and pop with one entry held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hC1;
        step();
        out_ready = 1'b1;
        in_data   = 32'hC2;
        step(); check("simul_data", out_data, 32'hC2); check("simul_occ", {30'd0, occupancy}, 32'd1);
        in_valid = 1'b0;
        step();

        // Asynchronous reset mid-cycle while full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hD1;
        step();
        in_data = 32'hD2;
        step();
        in_valid = 1'b0;
        check("pre_rst_occ", {30'd0, occupancy}, 32'd2);
        #1 rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_occ", {30'd0, occupancy}, 32'd0);
        check("arst_data", out_data, RV);
        check("arst_rdy", {31'd0, in_ready}, 32'd0);
        step();
        check("arst_rdy_held", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1 check("arst_release_rdy", {31'd0, in_ready}, 32'd1);

        // Random traffic against the queue model.
        for (int i = 0; i < 10000; i++) begin
            step();
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = $urandom;
            flush     = ($urandom_range(0, 31) == 0);
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
